// File: rtl/button_press_classifier.sv
// Classifies a debounced sample-pulse stream into short presses, long presses,
// auto-repeat ticks and releases, with a registered "held" level.
module button_press_classifier #(
  parameter int SAMPLE_PERIOD  = 65_536,
  parameter int LONG_SAMPLES   = 64,
  parameter int REPEAT_SAMPLES = 16,
  parameter int IN_ACTIVE_LOW  = 0
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic in_pulse,
  output logic short_press,
  output logic long_press,
  output logic repeat_press,
  output logic released,
  output logic held
);

  localparam int TIMEOUT_CYCLES = 2 * SAMPLE_PERIOD;
  localparam int REP_MAX        = (REPEAT_SAMPLES > 0) ? REPEAT_SAMPLES : 1;
  localparam int PW             = $clog2(LONG_SAMPLES + 1);
  localparam int GW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW             = $clog2(REP_MAX + 1);

  localparam logic [PW-1:0] LONG_V    = PW'(LONG_SAMPLES);
  localparam logic [GW-1:0] TIMEOUT_V = GW'(TIMEOUT_CYCLES);
  localparam logic [RW-1:0] REP_V     = RW'(REP_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pulse_ctr_q, pulse_ctr_d;
  logic [GW-1:0]   gap_ctr_q, gap_ctr_d;
  logic [RW-1:0]   rep_ctr_q, rep_ctr_d;
  logic            short_press_q, short_press_d;
  logic            long_press_q, long_press_d;
  logic            repeat_press_q, repeat_press_d;
  logic            released_q, released_d;
  logic            held_q, held_d;
  logic            pulse_act;

  assign pulse_act = (IN_ACTIVE_LOW != 0) ? ~in_pulse : in_pulse;

  always_comb begin
    state_d        = state_q;
    pulse_ctr_d    = pulse_ctr_q;
    gap_ctr_d      = gap_ctr_q;
    rep_ctr_d      = rep_ctr_q;
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    repeat_press_d = 1'b0;
    released_d     = 1'b0;
    case (state_q)
      IDLE: begin
        pulse_ctr_d = '0;
        gap_ctr_d   = '0;
        rep_ctr_d   = '0;
        if (pulse_act) begin
          state_d     = PRESSED;
          pulse_ctr_d = PW'(1);
        end
      end
      PRESSED: begin
        // A pulse always beats a pending timeout on the same cycle.
        if (pulse_act) begin
          gap_ctr_d = '0;
          if (pulse_ctr_q == LONG_V - 1'b1) begin
            pulse_ctr_d  = LONG_V;
            rep_ctr_d    = '0;
            long_press_d = 1'b1;
            state_d      = LONG_HELD;
          end else begin
            pulse_ctr_d = pulse_ctr_q + 1'b1;
          end
        end else if (gap_ctr_q == TIMEOUT_V - 1'b1) begin
          short_press_d = 1'b1;
          released_d    = 1'b1;
          state_d       = IDLE;
          pulse_ctr_d   = '0;
          gap_ctr_d     = '0;
          rep_ctr_d     = '0;
        end else begin
          gap_ctr_d = gap_ctr_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (pulse_act) begin
          gap_ctr_d = '0;
          if (REPEAT_SAMPLES > 0) begin
            if (rep_ctr_q == REP_V - 1'b1) begin
              repeat_press_d = 1'b1;
              rep_ctr_d      = '0;
            end else begin
              rep_ctr_d = rep_ctr_q + 1'b1;
            end
          end else begin
            rep_ctr_d = '0;
          end
        end else if (gap_ctr_q == TIMEOUT_V - 1'b1) begin
          released_d  = 1'b1;
          state_d     = IDLE;
          pulse_ctr_d = '0;
          gap_ctr_d   = '0;
          rep_ctr_d   = '0;
        end else begin
          gap_ctr_d = gap_ctr_q + 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        pulse_ctr_d = '0;
        gap_ctr_d   = '0;
        rep_ctr_d   = '0;
      end
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      pulse_ctr_q    <= '0;
      gap_ctr_q      <= '0;
      rep_ctr_q      <= '0;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      repeat_press_q <= 1'b0;
      released_q     <= 1'b0;
      held_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      pulse_ctr_q    <= pulse_ctr_d;
      gap_ctr_q      <= gap_ctr_d;
      rep_ctr_q      <= rep_ctr_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      repeat_press_q <= repeat_press_d;
      released_q     <= released_d;
      held_q         <= held_d;
    end
  end

  assign short_press  = short_press_q;
  assign long_press   = long_press_q;
  assign repeat_press = repeat_press_q;
  assign released     = released_q;
  assign held         = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed scenarios on an active-high and an active-low instance driven with
// complementary inputs; expected per-cycle outputs flow through a queue.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin = 1'b0;
  logic pin_n;
  logic sp_h, lp_h, rp_h, rl_h, hd_h;
  logic sp_l, lp_l, rp_l, rl_l, hd_l;

  int total = 0;
  int bad   = 0;

  localparam int N = 40;

  logic [4:0] exp_q[$];

  assign pin_n = ~pin;

  always #5 clk = ~clk;

  button_press_classifier #(
    .SAMPLE_PERIOD(4), .LONG_SAMPLES(3), .REPEAT_SAMPLES(2), .IN_ACTIVE_LOW(0)
  ) dut_h (
    .sys_clk(clk), .sys_rst(rst), .in_pulse(pin),
    .short_press(sp_h), .long_press(lp_h), .repeat_press(rp_h),
    .released(rl_h), .held(hd_h)
  );

  button_press_classifier #(
    .SAMPLE_PERIOD(4), .LONG_SAMPLES(3), .REPEAT_SAMPLES(2), .IN_ACTIVE_LOW(1)
  ) dut_l (
    .sys_clk(clk), .sys_rst(rst), .in_pulse(pin_n),
    .short_press(sp_l), .long_press(lp_l), .repeat_press(rp_l),
    .released(rl_l), .held(hd_l)
  );

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Output vector order: {short, long, repeat, released, held}.
  task automatic run(input string tag,
                     input logic [63:0] pm, input logic [63:0] rm,
                     input logic [63:0] sm, input logic [63:0] lm,
                     input logic [63:0] pr, input logic [63:0] relm,
                     input logic [63:0] hm);
    logic [4:0] e, oh, ol;
    for (int n = 0; n < N; n++) begin
      @(posedge clk);
      #1;
      if (n > 0) begin
        e  = exp_q.pop_front();
        oh = {sp_h, lp_h, rp_h, rl_h, hd_h};
        ol = {sp_l, lp_l, rp_l, rl_l, hd_l};
        total++;
        assert (oh === e) else begin
          bad++;
          $error("FAIL %s_hi cyc=%0d got=%b exp=%b", tag, n, oh, e);
        end
        total++;
        assert (ol === e) else begin
          bad++;
          $error("FAIL %s_lo cyc=%0d got=%b exp=%b", tag, n, ol, e);
        end
      end
      rst = rm[n];
      pin = pm[n];
      if (n + 1 < N)
        exp_q.push_back({sm[n+1], lm[n+1], pr[n+1], relm[n+1], hm[n+1]});
    end
  endtask

  initial begin
    logic [63:0] p, r, s, l, q, rl, h;

    // Short press; a pulse during reset must be ignored.
    p = '0; p[1] = 1'b1; p[10] = 1'b1; p[14] = 1'b1;
    r = rng(0, 2);
    s = '0; s[23] = 1'b1;
    l = '0; q = '0;
    rl = '0; rl[23] = 1'b1;
    h = rng(11, 22);
    run("short", p, r, s, l, q, rl, h);

    // Long press with one repeat tick, release without short.
    p = '0; p[10] = 1'b1; p[14] = 1'b1; p[18] = 1'b1; p[22] = 1'b1; p[26] = 1'b1;
    r = rng(0, 2);
    s = '0;
    l = '0; l[19] = 1'b1;
    q = '0; q[27] = 1'b1;
    rl = '0; rl[35] = 1'b1;
    h = rng(11, 34);
    run("long", p, r, s, l, q, rl, h);

    // Reset mid long hold aborts silently; a later press starts from IDLE.
    p = '0; p[10] = 1'b1; p[14] = 1'b1; p[18] = 1'b1; p[30] = 1'b1;
    r = rng(0, 2); r[20] = 1'b1;
    s = '0; s[39] = 1'b1;
    l = '0; l[19] = 1'b1;
    q = '0;
    rl = '0; rl[39] = 1'b1;
    h = rng(11, 20) | rng(31, 38);
    run("abort", p, r, s, l, q, rl, h);

    // Gap of 7 idle cycles survives; 8 idle cycles time out, then re-press.
    p = '0; p[10] = 1'b1; p[18] = 1'b1; p[27] = 1'b1;
    r = rng(0, 2);
    s = '0; s[27] = 1'b1; s[36] = 1'b1;
    l = '0; q = '0;
    rl = '0; rl[27] = 1'b1; rl[36] = 1'b1;
    h = rng(11, 26) | rng(28, 35);
    run("gap", p, r, s, l, q, rl, h);

    total++;
    assert (exp_q.size() === 0) else begin
      bad++;
      $error("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
